// File: rtl/dump_pkg.sv
// Shared types and constants for the architectural state dump engine.
package dump_pkg;

   localparam int TAG_W = 2;

   // Kind of word carried on the dump stream.
   typedef enum logic [TAG_W-1:0] {
      TAG_PC  = 2'd0,
      TAG_REG = 2'd1,
      TAG_MEM = 2'd2
   } dump_tag_e;

   // Sequencer states: PC is emitted straight out of IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REG   = 2'd1,
      ST_MEM   = 2'd2,
      ST_DRAIN = 2'd3
   } dump_state_e;

   // Index width wide enough for the larger of the two dumped ranges (never 0).
   function automatic int idx_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Collects three big-endian bytes from the byte-wide memory port and presents
// the assembled 32-bit word together with the fourth (live) byte.
module byte_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance_i,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic [1:0]  byte_next_o,
   output logic        last_byte_o
);

   logic [23:0] acc_q;
   logic [23:0] acc_d;
   logic [1:0]  byte_q;
   logic [1:0]  byte_d;

   // Next accumulator and byte position: clear wins over advance.
   always_comb begin
      acc_d  = acc_q;
      byte_d = byte_q;
      if (clear_i) begin
         acc_d  = 24'd0;
         byte_d = 2'd0;
      end else if (advance_i) begin
         acc_d  = {acc_q[15:0], byte_i};
         byte_d = byte_q + 2'd1;
      end else begin
         acc_d  = acc_q;
         byte_d = byte_q;
      end
   end

   // Accumulator and byte counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= 24'd0;
         byte_q <= 2'd0;
      end else begin
         acc_q  <= acc_d;
         byte_q <= byte_d;
      end
   end

   // Lowest address lands in the MSB; the live byte completes the word.
   assign word_o      = {acc_q, byte_i};
   assign byte_next_o = byte_d;
   assign last_byte_o = (byte_q == 2'd3);

endmodule

// File: rtl/arch_state_dumper.sv
// End-of-run architectural state dump: PC, register file, then a window of
// byte-addressed data memory, streamed as tagged 32-bit words on valid/ready.
module arch_state_dumper
   import dump_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                NUM_REGS  = 32,
   parameter int                MEM_WORDS = 12,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] MEM_BASE  = {ADDR_W{1'b0}},
   parameter int                IDX_W     = idx_width(NUM_REGS, MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] pc,
   output logic [4:0]        rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] dm_raddr,
   input  logic [7:0]        dm_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

   dump_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   dump_tag_e         out_tag_q, out_tag_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
   logic [4:0]        rf_raddr_q, rf_raddr_d;
   logic [ADDR_W-1:0] dm_raddr_q, dm_raddr_d;

   logic              slot_free;
   logic              pk_advance;
   logic              pk_clear;
   logic [31:0]       pk_word;
   logic [1:0]        pk_byte_next;
   logic              pk_last_byte;

   byte_word_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .advance_i   (pk_advance),
      .clear_i     (pk_clear),
      .byte_i      (dm_rdata),
      .word_o      (pk_word),
      .byte_next_o (pk_byte_next),
      .last_byte_o (pk_last_byte)
   );

   // The single output register may be reloaded once it is empty or being taken.
   assign slot_free = !out_valid_q || out_ready;

   // Sequencer: next state, index and output slot contents.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_index_d = out_index_q;
      pk_advance  = 1'b0;
      pk_clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               out_valid_d = 1'b1;
               out_data_d  = pc;
               out_tag_d   = TAG_PC;
               out_index_d = {IDX_W{1'b0}};
               busy_d      = 1'b1;
               idx_d       = {IDX_W{1'b0}};
               pk_clear    = 1'b1;
               state_d     = ST_REG;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REG: begin
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_data_d  = rf_rdata;
               out_tag_d   = TAG_REG;
               out_index_d = idx_q;
               if (idx_q == LAST_REG) begin
                  idx_d   = {IDX_W{1'b0}};
                  state_d = ST_MEM;
               end else begin
                  idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = ST_REG;
            end
         end
         ST_MEM: begin
            if (!pk_last_byte) begin
               // Leading bytes are collected regardless of the consumer.
               pk_advance = 1'b1;
            end else if (slot_free) begin
               out_valid_d = 1'b1;
               out_data_d  = DATA_W'(pk_word);
               out_tag_d   = TAG_MEM;
               out_index_d = idx_q;
               pk_clear    = 1'b1;
               if (idx_q == LAST_MEM) begin
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read addresses are registered from next-state values so they are valid in the cycle they are used.
   always_comb begin
      rf_raddr_d = 5'd0;
      dm_raddr_d = {ADDR_W{1'b0}};
      if (state_d == ST_REG) begin
         rf_raddr_d = 5'(idx_d);
      end else if (state_d == ST_MEM) begin
         dm_raddr_d = MEM_BASE + ADDR_W'({idx_d, 2'b00}) + ADDR_W'(pk_byte_next);
      end else begin
         rf_raddr_d = 5'd0;
         dm_raddr_d = {ADDR_W{1'b0}};
      end
   end

   // State, index, output slot and address registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= {IDX_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         out_tag_q   <= TAG_PC;
         out_index_q <= {IDX_W{1'b0}};
         rf_raddr_q  <= 5'd0;
         dm_raddr_q  <= {ADDR_W{1'b0}};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_index_q <= out_index_d;
         rf_raddr_q  <= rf_raddr_d;
         dm_raddr_q  <= dm_raddr_d;
      end
   end

   assign rf_raddr  = rf_raddr_q;
   assign dm_raddr  = dm_raddr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_index = out_index_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_arch_state_dumper.sv
// Scoreboard bench for arch_state_dumper: a default instance and a small
// parameter variant, with simple register-file and byte-memory models.
module tb_arch_state_dumper;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  tag;
      logic [4:0]  idx;
      logic [31:0] edge_n;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [1:0] start_v;
   logic [31:0] pc0, pc1;
   logic rand_rdy;

   // Default instance signals
   logic [4:0]  rf_raddr0;
   logic [31:0] rf_rdata0;
   logic [31:0] dm_raddr0;
   logic [7:0]  dm_rdata0;
   logic        out_valid0, out_ready0, busy0, done0;
   logic [31:0] out_data0;
   logic [1:0]  out_tag0;
   logic [4:0]  out_index0;

   // Variant instance signals
   logic [4:0]  rf_raddr1;
   logic [31:0] rf_rdata1;
   logic [31:0] dm_raddr1;
   logic [7:0]  dm_rdata1;
   logic        out_valid1, out_ready1, busy1, done1;
   logic [31:0] out_data1;
   logic [1:0]  out_tag1;
   logic [1:0]  out_index1;

   exp_t sb[$];
   int n_chk, n_fail, cyc;
   int e0[2];
   int done_cnt[2];
   int done_edge[2];
   logic timed[2];
   logic held_v[2];
   logic [31:0] held_d[2];
   logic [6:0]  held_ti[2];

   // Register i holds 0x100+i; memory byte k holds k.
   assign rf_rdata0 = 32'h100 + {27'd0, rf_raddr0};
   assign rf_rdata1 = 32'h100 + {27'd0, rf_raddr1};
   assign dm_rdata0 = dm_raddr0[7:0];
   assign dm_rdata1 = dm_raddr1[7:0];
   assign out_ready1 = 1'b1;

   arch_state_dumper u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pc(pc0),
      .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
      .dm_raddr(dm_raddr0), .dm_rdata(dm_rdata0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .out_tag(out_tag0), .out_index(out_index0), .busy(busy0), .done(done0)
   );

   arch_state_dumper #(.NUM_REGS(4), .MEM_WORDS(2), .MEM_BASE(32'h10)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pc(pc1),
      .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
      .dm_raddr(dm_raddr1), .dm_rdata(dm_rdata1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_tag(out_tag1), .out_index(out_index1), .busy(busy1), .done(done1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Expected word stream for instance i; edge numbers assume out_ready=1.
   task automatic push_dump(input int i, input logic [31:0] pcval);
      int n, m;
      logic [31:0] base, k;
      exp_t e;
      n    = (i == 0) ? 32 : 4;
      m    = (i == 0) ? 12 : 2;
      base = (i == 0) ? 32'h0 : 32'h10;
      done_edge[i] = n + 4 * m + 1;
      e = '{data: pcval, tag: 2'd0, idx: 5'd0, edge_n: 32'd0};
      sb.push_back(e);
      for (int r = 0; r < n; r++) begin
         e = '{data: 32'h100 + 32'(r), tag: 2'd1, idx: 5'(r), edge_n: 32'(r + 1)};
         sb.push_back(e);
      end
      for (int j = 0; j < m; j++) begin
         k = base + 32'(4 * j);
         e.data   = {k[7:0], 8'(k + 32'd1), 8'(k + 32'd2), 8'(k + 32'd3)};
         e.tag    = 2'd2;
         e.idx    = 5'(j);
         e.edge_n = 32'(n + 4 + 4 * j);
         sb.push_back(e);
      end
   endtask

   // Per-cycle observation of one instance, taken at the falling edge.
   task automatic mon(input int i, input logic v, input logic r, input logic [31:0] d,
                      input logic [1:0] t, input logic [4:0] x, input logic dn, input logic bz);
      exp_t e;
      if (held_v[i]) begin
         check_eq("stall_valid", {31'd0, v}, 32'd1);
         check_eq("stall_data", d, held_d[i]);
         check_eq("stall_tag_idx", {25'd0, t, x}, {25'd0, held_ti[i]});
      end
      held_v[i]  = v && !r;
      held_d[i]  = d;
      held_ti[i] = {t, x};
      if (v && r) begin
         check_eq("word_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("word_data", d, e.data);
            check_eq("word_tag_idx", {25'd0, t, x}, {25'd0, e.tag, e.idx});
            if (timed[i]) check_eq("word_edge", 32'(cyc - e0[i]), e.edge_n);
         end
      end
      if (dn) begin
         done_cnt[i]++;
         check_eq("done_busy", {31'd0, bz}, 32'd0);
         check_eq("done_all_words", 32'(sb.size()), 32'd0);
         if (timed[i]) check_eq("done_edge", 32'(cyc - e0[i]), 32'(done_edge[i]));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            mon(0, out_valid0, out_ready0, out_data0, out_tag0, out_index0, done0, busy0);
            mon(1, out_valid1, out_ready1, out_data1, out_tag1, {3'd0, out_index1}, done1, busy1);
         end else begin
            held_v[0] = 1'b0;
            held_v[1] = 1'b0;
         end
      end
   end

   // Consumer ready: always 1, or about 30% low when randomised.
   initial begin
      out_ready0 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready0 = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
      end
   end

   task automatic chk_zero(input int i);
      if (i == 0) begin
         check_eq("zero_ctl", {29'd0, out_valid0, busy0, done0}, 32'd0);
         check_eq("zero_data", out_data0, 32'd0);
         check_eq("zero_tag_idx", {25'd0, out_tag0, out_index0}, 32'd0);
         check_eq("zero_rf_addr", {27'd0, rf_raddr0}, 32'd0);
         check_eq("zero_dm_addr", dm_raddr0, 32'd0);
      end else begin
         check_eq("zero_ctl", {29'd0, out_valid1, busy1, done1}, 32'd0);
         check_eq("zero_data", out_data1, 32'd0);
         check_eq("zero_tag_idx", {28'd0, out_tag1, out_index1}, 32'd0);
         check_eq("zero_rf_addr", {27'd0, rf_raddr1}, 32'd0);
         check_eq("zero_dm_addr", dm_raddr1, 32'd0);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge E0.
   task automatic start_dump(input int i, input logic [31:0] pcval);
      if (i == 0) pc0 = pcval; else pc1 = pcval;
      start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      e0[i] = cyc;
      push_dump(i, pcval);
   endtask

   task automatic goto_edge(input int i, input int k);
      while (cyc - e0[i] < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int i, input int budget);
      int base, n;
      base = done_cnt[i];
      n = 0;
      while (done_cnt[i] == base && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("done_seen", 32'(done_cnt[i]), 32'(base + 1));
   endtask

   initial begin
      int dc;
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      start_v = 2'b00;
      pc0 = 32'd0;
      pc1 = 32'd0;
      rand_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e0[i] = 0; done_cnt[i] = 0; done_edge[i] = 0;
         timed[i] = 1'b0; held_v[i] = 1'b0; held_d[i] = 32'd0; held_ti[i] = 7'd0;
      end

      // Reset for two cycles, then idle with no start.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_zero(0);
         chk_zero(1);
      end
      @(posedge clk);
      #1;

      // Default dump with ready=1, ignored starts at E10 and at the done edge,
      // then a start one cycle later that begins a fresh dump.
      timed[0] = 1'b1;
      start_dump(0, 32'h0040_0020);
      goto_edge(0, 9);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      goto_edge(0, 80);
      pc0 = 32'hDEAD_0000;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      pc0 = 32'h0040_1000;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      e0[0] = cyc;
      push_dump(0, 32'h0040_1000);
      wait_done(0, 200);
      check_eq("done_count_two_dumps", 32'(done_cnt[0]), 32'd2);

      // Random backpressure.
      timed[0] = 1'b0;
      rand_rdy = 1'b1;
      dc = done_cnt[0];
      start_dump(0, 32'h1234_5678);
      wait_done(0, 2000);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      check_eq("done_once_backpressure", 32'(done_cnt[0]), 32'(dc + 1));
      rand_rdy = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end

      // Reset in the middle of a dump.
      timed[0] = 1'b1;
      start_dump(0, 32'hA5A5_0001);
      goto_edge(0, 19);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_zero(0);
      rst_n = 1'b1;
      sb.delete();
      dc = done_cnt[0];
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check_eq("no_done_after_reset", 32'(done_cnt[0]), 32'(dc));
      chk_zero(0);
      start_dump(0, 32'hA5A5_0002);
      wait_done(0, 200);

      // Parameter variant.
      timed[1] = 1'b1;
      start_dump(1, 32'hBFC0_0000);
      wait_done(1, 100);
      check_eq("variant_done_count", 32'(done_cnt[1]), 32'd1);

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_eq("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
